// File: rtl/xup_serial_word_capture.sv
// xup_serial_word_capture: sequences an upstream shift register and reassembles its serial output into a word
module xup_serial_word_capture #(
  parameter int SIZE = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dir,
  input  logic            serial_in,
  output logic            sr_load,
  output logic            sr_en,
  output logic            sr_dir,
  output logic [SIZE-1:0] data_out,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            busy,
  output logic            overrun,
  input  logic            clr_overrun
);
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, VALID} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic accept, reject;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state and start acceptance/rejection
  always_comb begin
    state_nx = state;
    accept = 1'b0;
    reject = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        state_nx = start ? LOAD : IDLE;
      end
      LOAD: begin
        reject = start;
        state_nx = SHIFT;
      end
      SHIFT: begin
        reject = start;
        state_nx = (cnt == LAST) ? VALID : SHIFT;
      end
      VALID: begin
        accept = start && data_ready;
        reject = start && !data_ready;
        state_nx = data_ready ? (start ? LOAD : IDLE) : VALID;
      end
    endcase
  end
  // registered outputs derived from the next state, plus sampling datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_load <= 1'b0;
      sr_en <= 1'b0;
      sr_dir <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      cnt <= '0;
    end else begin
      sr_load <= state_nx == LOAD;
      sr_en <= state_nx == SHIFT;
      data_valid <= state_nx == VALID;
      busy <= state_nx != IDLE;
      if (accept) sr_dir <= dir;
      overrun <= reject ? 1'b1 : (clr_overrun ? 1'b0 : overrun);
      if (state == LOAD) cnt <= '0;
      else if (state == SHIFT && cnt != LAST) cnt <= cnt + 1'b1;
      if (state == SHIFT)
        data_out <= sr_dir ? {serial_in, data_out[SIZE-1:1]} : {data_out[SIZE-2:0], serial_in};
    end
  end
endmodule

// File: doc/xup_serial_word_capture.md
# xup_serial_word_capture

Sequencer and deserializer that sits directly downstream of the XUP shift register. It pulses the shift register's `load`, enables it for exactly SIZE shift cycles and samples its `shift_out` each cycle. It then presents the reassembled word on a valid/ready interface. It is the building block for loop-back checks and for feeding serial streams into parallel logic.

## Interface
- `SIZE`, 6: word width in bits; must match the upstream shift register SIZE; legal range 2..32.
- `clk` in 1: rising-edge clock, shared with the upstream shift register.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one word transfer; sampled on the clock edge.
- `dir` in 1: transfer direction, sampled when `start` is accepted.
  - 0: upstream shifts toward MSB; first bit is the word MSB.
  - 1: upstream shifts toward LSB; first bit is the word LSB.
- `serial_in` in 1: connects to upstream `shift_out`.
- `sr_load` out 1: drives upstream `load`.
- `sr_en` out 1: drives upstream `en`.
- `sr_dir` out 1: drives upstream `dir`.
- `data_out` out SIZE: reassembled word.
- `data_valid` out 1: `data_out` holds a complete word.
- `data_ready` in 1: consumer accepts the word.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky; set when `start` is rejected.
- `clr_overrun` in 1: synchronous clear of `overrun`.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `sr_load` = `sr_en` = `sr_dir` = 0
  - `data_out` = 0
  - `data_valid` = `busy` = `overrun` = 0
  - bit counter = 0
- State machine:
  - IDLE: on `start`, latch `dir` into `sr_dir` and go to LOAD.
  - LOAD: `sr_load` = 1 for one cycle, clear bit counter, go to SHIFT.
  - SHIFT: `sr_en` = 1. Each edge samples `serial_in` and increments the counter. After the SIZE-th sample, go to VALID.
  - VALID: `data_valid` = 1 and `data_out` is frozen.
    - `data_valid && data_ready`: go to IDLE.
    - `data_valid && data_ready && start`: go directly to LOAD, with `dir` re-latched.
- Assembly:
  - `sr_dir` = 0: `data_out <= {data_out[SIZE-2:0], serial_in}`.
  - `sr_dir` = 1: `data_out <= {serial_in, data_out[SIZE-1:1]}`.
- `data_out` is not cleared at LOAD. After SIZE samples every bit has been overwritten.
- Bit counter width is `$clog2(SIZE)`. The terminal value is SIZE-1; the counter never wraps inside SHIFT.
- `start` in LOAD or SHIFT, or in VALID without `data_ready`, is ignored and sets `overrun`. It is not queued.
- `clr_overrun` and a rejected `start` in the same cycle: `overrun` = 1 (set wins).
- `dir` changes after acceptance have no effect until the next accepted `start`.

## Timing
- `start` sampled at edge E0 (IDLE):
  - `sr_load` high in cycle 1.
  - `sr_en` high in cycles 2..SIZE+1.
  - `data_valid` high from cycle SIZE+2.
- Latency from accepted `start` to `data_valid` is SIZE+2 cycles. Back-to-back throughput is one word per SIZE+2 cycles with `data_ready` held high.
- `sr_en` falls in the same edge that raises `data_valid`. The upstream register never receives an extra shift.
- Handshake completes on the edge where `data_valid && data_ready`; `data_valid` is low in the following cycle unless a new word completes.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for `clk`. `sr_en` is deasserted asynchronously so upstream stops shifting. After release, the block is in IDLE and needs a new `start`.

## Test plan
- SIZE=6, upstream `parallel_in` = 6'b101101, `dir` = 0, pulse `start`, `data_ready` = 1 -> `sr_load` high one cycle, `sr_en` high exactly 6 cycles, `data_out` = 6'b101101 with `data_valid` at cycle 8, `busy` low at cycle 9.
- Same stimulus with `dir` = 1 -> `data_out` = 6'b101101 and `sr_dir` = 1 for the whole transfer.
- `data_ready` held 0 for 5 cycles after `data_valid` -> `data_out` stable and `data_valid` high throughout. Handshake on the 6th cycle, then IDLE.
- `start` pulsed mid-SHIFT and again in VALID with `data_ready` = 0 -> transfer unaffected, `overrun` = 1. `clr_overrun` clears it; `clr_overrun` together with a rejected `start` leaves it at 1.
- `start` and `data_ready` high together in VALID -> next `sr_load` the following cycle. Two words of 6'b101101 then 6'b010010 are received correctly, 8 cycles apart.
- `rst_n` = 0 at the 3rd `sr_en` cycle -> `sr_en`, `busy` and `data_valid` drop without a clock edge. After release, a fresh `start` yields a correct word.
